fetch_sequencer: RTL
====================

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 Parameter W, default 32, SHALL set the address/instruction word width.
REQ-002 Parameter NOP, default 32'h0000_0000, SHALL set the instruction value driven when no valid instruction is held.
REQ-003 clk  input  1  SHALL be the clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  SHALL be the reset: synchronous, active-high.
REQ-005 fetch_addr  input  W  SHALL carry the current PC register value.
REQ-006 redirect  input  1  SHALL flag a taken branch or flush from a later stage.
REQ-007 id_stall  input  1  SHALL flag that decode cannot accept a new instruction this cycle.
REQ-008 mem_ack  input  1  SHALL be a one-cycle pulse from instruction memory meaning mem_rdata is valid.
REQ-009 mem_rdata  input  W  SHALL be the fetched instruction word.
REQ-010 mem_req  output  1  SHALL request an instruction memory read.
REQ-011 mem_addr  output  W  SHALL be the read address.
REQ-012 pc_stall  output  1  SHALL hold the PC register when 1 and let it update when 0.
REQ-013 inst_valid  output  1  SHALL flag that inst/inst_pc hold a live instruction for decode.
REQ-014 inst  output  W  SHALL be the instruction presented to decode.
REQ-015 inst_pc  output  W  SHALL be the address of inst.

Function
REQ-016 The FSM SHALL have states IDLE, ISSUE, WAIT, HOLD and DROP.
REQ-017 IDLE SHALL go to ISSUE on the next edge unconditionally; it drives mem_req=0 and pc_stall=1.
REQ-018 ISSUE SHALL drive mem_req=1 and mem_addr=fetch_addr, and SHALL capture fetch_addr into internal req_addr.
REQ-019 WAIT and DROP SHALL drive mem_req=1 and mem_addr=req_addr; IDLE and HOLD SHALL drive mem_req=0.
REQ-020 ISSUE without mem_ack and without redirect SHALL go to WAIT; WAIT SHALL stay in WAIT under the same conditions.
REQ-021 In ISSUE/WAIT, mem_ack with redirect=0 and (id_stall=0 or inst_valid=0) SHALL load inst<=mem_rdata, inst_pc<=req_addr (fetch_addr in ISSUE) and inst_valid<=1, then go to ISSUE.
REQ-022 In ISSUE/WAIT, mem_ack with redirect=0, id_stall=1 and inst_valid=1 SHALL store mem_rdata and its address in a one-entry buffer, then go to HOLD.
REQ-023 HOLD with id_stall=0 and redirect=0 SHALL move the buffer into inst/inst_pc with inst_valid<=1, then go to ISSUE; with id_stall=1 it SHALL stay in HOLD.
REQ-024 In ISSUE/WAIT, redirect without mem_ack SHALL go to DROP.
REQ-025 DROP SHALL discard the data returned with mem_ack and go to ISSUE; without mem_ack it SHALL stay in DROP.
REQ-026 Redirect together with mem_ack in ISSUE/WAIT/DROP SHALL discard the data and go to ISSUE.
REQ-027 Redirect in HOLD SHALL discard the buffer and go to ISSUE.
REQ-028 Redirect in any state except IDLE SHALL force inst_valid<=0 and inst<=NOP; redirect SHALL take priority over id_stall.
REQ-029 pc_stall SHALL be 0 only in cycles with redirect=1 (not IDLE), or with mem_ack=1 in ISSUE/WAIT; it SHALL be 1 in all other cycles.
REQ-030 With no instruction delivered, inst_valid SHALL hold while id_stall=1 and SHALL clear (inst<=NOP) when id_stall=0.
REQ-031 mem_addr and req_addr SHALL remain stable from ISSUE until mem_ack, including through DROP.
REQ-032 Best-case throughput SHALL be one instruction per cycle with mem_ack asserted in ISSUE.

Reset
REQ-033 rst SHALL force state IDLE, mem_req=0, mem_addr=0, pc_stall=1, inst_valid=0, inst=NOP, inst_pc=0, and SHALL clear req_addr and the buffer.
REQ-034 rst asserted mid-request SHALL abandon the request; a later mem_ack SHALL be ignored in IDLE.

Verification
REQ-035 Reset, fetch_addr=0x0, mem_ack each ISSUE cycle with rdata=0x11,0x22 -> inst 0x11@0x0, 0x22@0x4 on consecutive cycles, pc_stall=0 on each ack cycle.
REQ-036 Reset, then mem_ack 3 cycles after ISSUE at 0x0 -> pc_stall=1 and mem_addr=0x0 for 3 cycles; inst_valid rises after the ack edge.
REQ-037 Reset, inst_valid=1, id_stall=1, ack rdata=0x33 -> HOLD, mem_req=0; id_stall falls -> inst=0x33, inst_valid=1, next cycle is ISSUE.
REQ-038 Reset, redirect in WAIT at 0x8, target 0x40, ack 2 cycles later with 0x99 -> 0x99 never valid, mem_addr=0x8 until ack, next ISSUE mem_addr=0x40.
REQ-039 Reset, redirect coincident with mem_ack and id_stall=1 -> data dropped, inst_valid=0, pc_stall=0, next state ISSUE.
REQ-040 Reset, rst asserted in WAIT with mem_ack next cycle -> all outputs at reset values, no instruction delivered.

Source files
------------

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: issues instruction-memory reads for the PC, parks
// one response while decode stalls, and drops responses made stale by a redirect.
module fetch_sequencer #(
    parameter int           W   = 32,
    parameter logic [W-1:0] NOP = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] fetch_addr,
    input  logic         redirect,
    input  logic         id_stall,
    input  logic         mem_ack,
    input  logic [W-1:0] mem_rdata,
    output logic         mem_req,
    output logic [W-1:0] mem_addr,
    output logic         pc_stall,
    output logic         inst_valid,
    output logic [W-1:0] inst,
    output logic [W-1:0] inst_pc
);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, HOLD, DROP} state_t;

    state_t       state, state_n;
    logic [W-1:0] req_addr, req_addr_n;
    logic [W-1:0] buf_data, buf_data_n;
    logic [W-1:0] buf_addr, buf_addr_n;
    logic [W-1:0] inst_n, inst_pc_n;
    logic         inst_valid_n;
    logic         load;
    logic [W-1:0] load_data, load_addr;
    logic [W-1:0] cur_addr;

    // ISSUE presents the live PC; every later cycle of the same request replays it.
    assign cur_addr = (state == ISSUE) ? fetch_addr : req_addr;

    always_comb begin
        // NOTE: every signal gets a default first so no path through the case infers a latch.
        state_n      = state;
        req_addr_n   = req_addr;
        buf_data_n   = buf_data;
        buf_addr_n   = buf_addr;
        inst_n       = inst;
        inst_pc_n    = inst_pc;
        inst_valid_n = inst_valid;
        load         = 1'b0;
        load_data    = mem_rdata;
        load_addr    = cur_addr;
        mem_req      = 1'b0;
        mem_addr     = req_addr;
        pc_stall     = 1'b1;

        case (state)
            IDLE: state_n = ISSUE;
            ISSUE, WAIT: begin
                mem_req    = 1'b1;
                mem_addr   = cur_addr;
                req_addr_n = cur_addr;
                if (redirect) begin
                    pc_stall = 1'b0;
                    state_n  = mem_ack ? ISSUE : DROP;
                end else if (mem_ack) begin
                    pc_stall = 1'b0;
                    if (!id_stall || !inst_valid) begin
                        load    = 1'b1;
                        state_n = ISSUE;
                    end else begin
                        buf_data_n = mem_rdata;
                        buf_addr_n = cur_addr;
                        state_n    = HOLD;
                    end
                end else begin
                    state_n = WAIT;
                end
            end
            DROP: begin
                mem_req  = 1'b1;
                pc_stall = !redirect;
                if (mem_ack) state_n = ISSUE;
            end
            HOLD: begin
                if (redirect) begin
                    pc_stall = 1'b0;
                    state_n  = ISSUE;
                end else if (!id_stall) begin
                    load      = 1'b1;
                    load_data = buf_data;
                    load_addr = buf_addr;
                    state_n   = ISSUE;
                end
            end
            default: state_n = IDLE;
        endcase

        // Redirect outranks both delivery and decode's stall.
        if (redirect && state != IDLE) begin
            inst_valid_n = 1'b0;
            inst_n       = NOP;
        end else if (load) begin
            inst_valid_n = 1'b1;
            inst_n       = load_data;
            inst_pc_n    = load_addr;
        end else if (!id_stall) begin
            inst_valid_n = 1'b0;
            inst_n       = NOP;
        end

        // Reset is synchronous, so the request outputs are forced idle during the reset cycle too.
        if (rst) begin
            mem_req  = 1'b0;
            mem_addr = '0;
            pc_stall = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only; reset clears the buffer
    // and req_addr as well, so an abandoned request leaves nothing stale behind.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            req_addr   <= '0;
            buf_data   <= '0;
            buf_addr   <= '0;
            inst       <= NOP;
            inst_pc    <= '0;
            inst_valid <= 1'b0;
        end else begin
            state      <= state_n;
            req_addr   <= req_addr_n;
            buf_data   <= buf_data_n;
            buf_addr   <= buf_addr_n;
            inst       <= inst_n;
            inst_pc    <= inst_pc_n;
            inst_valid <= inst_valid_n;
        end
    end

endmodule
